// File: rtl/systolic_loader_w_seq_if.sv
// rtl/systolic_loader_w_seq_if.sv - control and weight-enable bundle between array controller and loader
interface systolic_loader_w_seq_if #(
  parameter int PE_COL     = 8,
  parameter int BIT_ROW_ID = 3
);
  logic                  i_start;
  logic [BIT_ROW_ID:0]   i_num_rows;
  logic [PE_COL-1:0]     i_col_mask;
  logic                  i_dir;
  logic                  i_stall;
  logic                  i_abort;
  logic [BIT_ROW_ID-1:0] o_Systolic_En_ID;
  logic [PE_COL-1:0]     o_Systolic_En_W;
  logic                  o_busy;
  logic                  o_done;

  // Controller side: drives the sequence request, observes the enables.
  modport master (
    output i_start, i_num_rows, i_col_mask, i_dir, i_stall, i_abort,
    input  o_Systolic_En_ID, o_Systolic_En_W, o_busy, o_done
  );

  // Loader side.
  modport slave (
    input  i_start, i_num_rows, i_col_mask, i_dir, i_stall, i_abort,
    output o_Systolic_En_ID, o_Systolic_En_W, o_busy, o_done
  );
endinterface

// File: rtl/systolic_loader_w_seq.sv
// rtl/systolic_loader_w_seq.sv - weight-row load sequencer with DELAY-deep enable pipeline
module systolic_loader_w_seq #(
  parameter int PE_ROW     = 8,
  parameter int PE_COL     = 8,
  parameter int BIT_ROW_ID = 3,
  parameter int DELAY      = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  systolic_loader_w_seq_if.slave   bus
);

  localparam int CW = BIT_ROW_ID + 1;
  localparam logic [CW-1:0] PE_ROW_W = CW'(PE_ROW);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      num_q, num_d;
  logic [PE_COL-1:0]                  mask_q, mask_d;
  logic                               dir_q, dir_d;
  logic [CW-1:0]                      issue_q, issue_d;
  logic [3:0]                         drain_q, drain_d;
  logic [DELAY-1:0][BIT_ROW_ID-1:0]   id_pipe_q, id_pipe_d;
  logic [DELAY-1:0][PE_COL-1:0]       w_pipe_q, w_pipe_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;

  logic [CW-1:0]         n_clamped;
  logic [BIT_ROW_ID-1:0] issue_id;
  logic [BIT_ROW_ID-1:0] stage_id;
  logic [PE_COL-1:0]     stage_w;
  logic                  flush;

  // Requested row count never exceeds the physical array height.
  assign n_clamped = (bus.i_num_rows > PE_ROW_W) ? PE_ROW_W : bus.i_num_rows;

  // Row ID for the current issue; descending order counts down from N-1.
  // Modulo arithmetic is exact because every ID is below N <= 2**BIT_ROW_ID.
  assign issue_id = dir_q ? (num_q[BIT_ROW_ID-1:0] - issue_q[BIT_ROW_ID-1:0] - BIT_ROW_ID'(1))
                          : issue_q[BIT_ROW_ID-1:0];

  // Next-state logic: sequencer, stage-1 issue and pipeline shift.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    mask_d   = mask_q;
    dir_d    = dir_q;
    issue_d  = issue_q;
    drain_d  = drain_q;
    stage_id = '0;
    stage_w  = '0;
    flush    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          num_d   = n_clamped;
          mask_d  = bus.i_col_mask;
          dir_d   = bus.i_dir;
          issue_d = '0;
          state_d = (n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.i_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (!bus.i_stall) begin
          stage_id = issue_id;
          stage_w  = mask_q;
          issue_d  = issue_q + CW'(1);
          if (issue_d == num_q) begin
            state_d = S_DRAIN;
            drain_d = 4'(DELAY - 1);
          end
        end
      end
      S_DRAIN: begin
        if (bus.i_abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    id_pipe_d    = id_pipe_q;
    w_pipe_d     = w_pipe_q;
    for (int i = DELAY - 1; i > 0; i--) begin
      id_pipe_d[i] = id_pipe_q[i-1];
      w_pipe_d[i]  = w_pipe_q[i-1];
    end
    id_pipe_d[0] = stage_id;
    w_pipe_d[0]  = stage_w;
    if (flush) begin
      id_pipe_d = '0;
      w_pipe_d  = '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, config, counters, pipeline and registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      mask_q    <= '0;
      dir_q     <= 1'b0;
      issue_q   <= '0;
      drain_q   <= '0;
      id_pipe_q <= '0;
      w_pipe_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      mask_q    <= mask_d;
      dir_q     <= dir_d;
      issue_q   <= issue_d;
      drain_q   <= drain_d;
      id_pipe_q <= id_pipe_d;
      w_pipe_q  <= w_pipe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_Systolic_En_ID = id_pipe_q[DELAY-1];
  assign bus.o_Systolic_En_W  = w_pipe_q[DELAY-1];
  assign bus.o_busy           = busy_q;
  assign bus.o_done           = done_q;

endmodule
